// File: rtl/seq_detector.sv
// seq_detector
//   Streaming, parametrised sequence detector. Accepts one SYM_W-bit symbol
//   per enabled clock, keeps the last PAT_LEN accepted symbols and compares
//   them against a programmable pattern. A match gives a registered one-cycle
//   pulse on y and bumps a saturating hit counter. Overlapping detection keeps
//   the history after a match; non-overlapping detection flushes it.
//
// Parameters
//   SYM_W    symbol width in bits (>=1)
//   PAT_LEN  pattern length in symbols (>=2)
//   CNT_W    hit counter width (>=1)
//   FILL_W   width of fill, derived from PAT_LEN; leave at its default
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low; clears all state
//   en       symbol valid; sym is accepted on a rising edge with en=1
//   sym      incoming symbol
//   pattern  target; symbol k (k=0 oldest) at bits [k*SYM_W +: SYM_W]
//   overlap  1 = overlapping matches, 0 = flush history after each match
//   clr      synchronous flush of history, fill, y and hit_cnt (beats en)
//   y        registered match pulse
//   fill     number of valid symbols in the history, 0..PAT_LEN
//   hit_cnt  saturating match count
//
// Configuration macro
//   SEQDET_HITCNT_EN  when defined the hit counter is built; otherwise
//                     hit_cnt is tied to zero.

module seq_detector #(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8,
  parameter int FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [SYM_W-1:0]         sym,
  input  logic [PAT_LEN*SYM_W-1:0] pattern,
  input  logic                     overlap,
  input  logic                     clr,
  output logic                     y,
  output logic [FILL_W-1:0]        fill,
  output logic [CNT_W-1:0]         hit_cnt
);

  localparam int                HIST_W    = PAT_LEN * SYM_W;
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(PAT_LEN);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } state_t;

  state_t              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_post;
  logic                y_q, y_d;
  logic                match;

  // State register: FSM state plus the history, fill and match pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
    end
  end

  // Next-state logic. Slot k of the history lives at bits [k*SYM_W +: SYM_W],
  // so shifting toward slot 0 is a right shift with sym entering at the top.
  // That layout matches the pattern layout, letting the match be a single
  // vector compare on the post-shift history.
  always_comb begin
    hist_shift = {sym, hist_q[HIST_W-1:SYM_W]};
    fill_post  = (state_q == FULL) ? FULL_FILL : fill_q + 1'b1;
    match      = (fill_post == FULL_FILL) && (hist_shift == pattern);

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    y_d     = 1'b0;

    if (clr) begin
      state_d = EMPTY;
      hist_d  = '0;
      fill_d  = '0;
    end else if (en) begin
      hist_d = hist_shift;
      y_d    = match;
      if (match && !overlap) begin
        state_d = EMPTY;
        fill_d  = '0;
      end else begin
        fill_d  = fill_post;
        state_d = (fill_post == FULL_FILL) ? FULL : FILLING;
      end
    end
  end

  // Output logic: all outputs come straight from registers.
  always_comb begin
    y    = y_q;
    fill = fill_q;
  end

`ifdef SEQDET_HITCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Hit counter: counts accepted matches and sticks at its maximum value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_cnt = cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector
//   Self-checking bench for seq_detector with default parameters. A queue of
//   accepted symbols models the history; expected y, fill and hit_cnt are
//   derived from it after every clock and compared against the DUT.

module tb_seq_detector;

  localparam int SYM_W   = 2;
  localparam int PAT_LEN = 3;
  localparam int CNT_W   = 8;
  localparam int FILL_W  = $clog2(PAT_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     reset;
  logic                     en;
  logic [SYM_W-1:0]         sym;
  logic [PAT_LEN*SYM_W-1:0] pattern;
  logic                     overlap;
  logic                     clr;
  logic                     y;
  logic [FILL_W-1:0]        fill;
  logic [CNT_W-1:0]         hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_hist[$];
  int m_cnt = 0;
  logic m_y = 1'b0;

  seq_detector #(
    .SYM_W(SYM_W),
    .PAT_LEN(PAT_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sym(sym),
    .pattern(pattern),
    .overlap(overlap),
    .clr(clr),
    .y(y),
    .fill(fill),
    .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FILL_W-1:0] exp_fill();
    return FILL_W'(m_hist.size());
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef SEQDET_HITCNT_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  // Apply the detector's rules to whatever inputs were sampled at this edge.
  task automatic model_step();
    bit ok;
    if (clr) begin
      m_hist.delete();
      m_cnt = 0;
      m_y   = 1'b0;
    end else if (en) begin
      m_hist.push_back(int'(sym));
      if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
      m_y = 1'b0;
      if (m_hist.size() == PAT_LEN) begin
        ok = 1'b1;
        for (int k = 0; k < PAT_LEN; k++)
          if (m_hist[k] != int'(pattern[k*SYM_W +: SYM_W])) ok = 1'b0;
        if (ok) begin
          m_y = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!overlap) m_hist.delete();
        end
      end
    end else begin
      m_y = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_cnt = 0;
    m_y   = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past the edge.
  task automatic drive_cycle(input logic e, input logic [SYM_W-1:0] s,
                             input logic c, input logic ov);
    @(negedge clk);
    en      = e;
    sym     = s;
    clr     = c;
    overlap = ov;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    // hold reset low with traffic present
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en  = 1'b1;
      sym = SYM_W'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if (y !== 1'b0 || fill !== '0 || hit_cnt !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cycle %0d: y=%b fill=%0d hit_cnt=%0d, required 0/0/0",
                 i, y, fill, hit_cnt);
      end
    end
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    model_reset();

    // build partial progress, then reset between edges
    pattern = {2'd1, 2'd1, 2'd1};
    drive_cycle(1'b1, 2'd1, 1'b0, 1'b1);
    drive_cycle(1'b1, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (y !== 1'b0 || fill !== '0 || hit_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: y=%b fill=%0d hit_cnt=%0d, required 0/0/0",
               y, fill, hit_cnt);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // one more symbol must not complete the old partial pattern
    drive_cycle(1'b1, 2'd1, 1'b0, 1'b1);
    n_checks++;
    if (y !== m_y || fill !== exp_fill()) begin
      n_fail++;
      $display("[TB] FAIL reset_progress_lost: y=%b fill=%0d, required y=%b fill=%0d",
               y, fill, m_y, exp_fill());
    end
  endtask

  task automatic test_basic_match();
    int stream [3] = '{1, 2, 3};
    pattern = {2'd3, 2'd2, 2'd1};
    drive_cycle(1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, SYM_W'(stream[i]), 1'b0, 1'b0);
      n_checks++;
      if (y !== m_y || fill !== exp_fill() || hit_cnt !== exp_cnt()) begin
        n_fail++;
        $display("[TB] FAIL basic_match step %0d: y=%b fill=%0d hit_cnt=%0d, required y=%b fill=%0d hit_cnt=%0d",
                 i, y, fill, hit_cnt, m_y, exp_fill(), exp_cnt());
      end
    end
    // pulse must drop once no further accept happens
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (y !== 1'b0 || hit_cnt !== exp_cnt()) begin
      n_fail++;
      $display("[TB] FAIL basic_pulse_width: y=%b hit_cnt=%0d, required y=0 hit_cnt=%0d",
               y, hit_cnt, exp_cnt());
    end
  endtask

  task automatic test_overlap();
    pattern = {2'd1, 2'd1, 2'd1};
    for (int mode = 1; mode >= 0; mode--) begin
      drive_cycle(1'b0, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
        drive_cycle(1'b1, 2'd1, 1'b0, mode[0]);
        n_checks++;
        if (y !== m_y || fill !== exp_fill() || hit_cnt !== exp_cnt()) begin
          n_fail++;
          $display("[TB] FAIL overlap ov=%0d accept %0d: y=%b fill=%0d hit_cnt=%0d, required y=%b fill=%0d hit_cnt=%0d",
                   mode, i + 1, y, fill, hit_cnt, m_y, exp_fill(), exp_cnt());
        end
      end
    end
  endtask

  task automatic test_gaps_clr();
    pattern = {2'd3, 2'd2, 2'd1};
    drive_cycle(1'b0, 2'd0, 1'b1, 1'b0);
    drive_cycle(1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd3, 1'b0, 1'b0);
    n_checks++;
    if (fill !== exp_fill() || y !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL gap_hold: fill=%0d y=%b, required fill=%0d y=0", fill, y, exp_fill());
    end
    drive_cycle(1'b1, 2'd2, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'd3, 1'b1, 1'b0);
    n_checks++;
    if (y !== 1'b0 || fill !== '0 || hit_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL clr_priority: y=%b fill=%0d hit_cnt=%0d, required 0/0/0", y, fill, hit_cnt);
    end
    drive_cycle(1'b1, 2'd3, 1'b0, 1'b0);
    n_checks++;
    if (y !== m_y || fill !== exp_fill()) begin
      n_fail++;
      $display("[TB] FAIL clr_discard: y=%b fill=%0d, required y=%b fill=%0d", y, fill, m_y, exp_fill());
    end
  endtask

  task automatic test_back_to_back();
    int stream [7] = '{1, 2, 1, 2, 1, 2, 1};
    pattern = {2'd1, 2'd2, 2'd1};
    drive_cycle(1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      // switch the pattern mid-stream; history must survive the change
      if (i == 5) pattern = {2'd2, 2'd1, 2'd2};
      drive_cycle(1'b1, SYM_W'(stream[i]), 1'b0, 1'b1);
      n_checks++;
      if (y !== m_y || fill !== exp_fill() || hit_cnt !== exp_cnt()) begin
        n_fail++;
        $display("[TB] FAIL back_to_back accept %0d: y=%b fill=%0d hit_cnt=%0d, required y=%b fill=%0d hit_cnt=%0d",
                 i + 1, y, fill, hit_cnt, m_y, exp_fill(), exp_cnt());
      end
    end
  endtask

  task automatic test_saturation();
    int n_pulse = 0;
    pattern = '0;
    drive_cycle(1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < CNT_MAX + 8; i++) begin
      drive_cycle(1'b1, 2'd0, 1'b0, 1'b1);
      if (y === 1'b1) n_pulse++;
      n_checks++;
      if (y !== m_y || fill !== exp_fill() || hit_cnt !== exp_cnt()) begin
        n_fail++;
        $display("[TB] FAIL saturation accept %0d: y=%b fill=%0d hit_cnt=%0d, required y=%b fill=%0d hit_cnt=%0d",
                 i + 1, y, fill, hit_cnt, m_y, exp_fill(), exp_cnt());
      end
    end
    n_checks++;
    if (n_pulse != CNT_MAX + 6) begin
      n_fail++;
      $display("[TB] FAIL saturation_pulses: got %0d pulses, required %0d", n_pulse, CNT_MAX + 6);
    end
  endtask

  task automatic test_random();
    drive_cycle(1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        for (int k = 0; k < PAT_LEN; k++)
          pattern[k*SYM_W +: SYM_W] = SYM_W'($urandom_range(0, 1));
      end
      drive_cycle(($urandom_range(0, 9) < 8), SYM_W'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0), 1'($urandom));
      n_checks++;
      if (y !== m_y || fill !== exp_fill() || hit_cnt !== exp_cnt()) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: y=%b fill=%0d hit_cnt=%0d, required y=%b fill=%0d hit_cnt=%0d",
                 i, y, fill, hit_cnt, m_y, exp_fill(), exp_cnt());
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    sym     = '0;
    pattern = '0;
    overlap = 1'b0;
    clr     = 1'b0;
    model_reset();

    test_reset();
    test_basic_match();
    test_overlap();
    test_gaps_clr();
    test_back_to_back();
    test_saturation();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
